// File: rtl/fifo_pkt.sv
// Packet-aware DTI FIFO with stream/threshold/packet release; write-to-valid latency 1 cycle (2 with REGOUT).
// Backpressure: din_ready drops when full unless a pop frees a slot in the same cycle; dout holds until dout_ready.
module fifo_pkt #(
  parameter int DIN       = 16,
  parameter int DEPTH     = 64,
  parameter int MODE      = 0,
  parameter int THRESHOLD = 0,
  parameter int REGOUT    = 0,
  localparam int CW       = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic [DIN-1:0] din_data,
  input  logic           din_valid,
  output logic           din_ready,
  output logic [DIN-1:0] dout_data,
  output logic           dout_valid,
  input  logic           dout_ready,
  output logic [CW:0]    level,
  output logic [CW:0]    pkt_cnt,
  output logic           full,
  output logic           empty
);

  logic [DIN-1:0] ram [DEPTH];
  logic [CW:0]    wptr;
  logic [CW:0]    rptr;
  logic [DIN-1:0] head;
  logic           rel;
  logic           pop;
  logic           wr;

  assign level = wptr - rptr;
  assign full  = (level == (CW+1)'(DEPTH));
  assign empty = (level == '0);
  assign head  = ram[rptr[CW-1:0]];

  // A stored eot always releases in threshold mode so a short final frame cannot stall.
  always_comb begin
    rel = 1'b0;
    case (MODE)
      1:       rel = !empty && ((level >= (CW+1)'(THRESHOLD)) || (pkt_cnt != '0));
      2:       rel = !empty && ((pkt_cnt != '0) || full);
      default: rel = !empty;
    endcase
  end

  assign pop       = rel && ((REGOUT != 0) ? (!dout_valid || dout_ready) : dout_ready);
  assign din_ready = !flush && (!full || pop);
  assign wr        = din_valid && din_ready;

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wptr    <= '0;
      rptr    <= '0;
      pkt_cnt <= '0;
    end else begin
      if (wr)
        wptr <= wptr + (CW+1)'(1);
      if (pop)
        rptr <= rptr + (CW+1)'(1);
      case ({wr && din_data[DIN-1], pop && head[DIN-1]})
        2'b10:   pkt_cnt <= pkt_cnt + (CW+1)'(1);
        2'b01:   pkt_cnt <= pkt_cnt - (CW+1)'(1);
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr)
      ram[wptr[CW-1:0]] <= din_data;
  end

  if (REGOUT != 0) begin : g_regout
    logic [DIN-1:0] oreg;
    logic           ovld;

    always_ff @(posedge clk) begin
      if (!rst || flush) begin
        oreg <= '0;
        ovld <= 1'b0;
      end else if (pop) begin
        oreg <= head;
        ovld <= 1'b1;
      end else if (dout_ready) begin
        ovld <= 1'b0;
      end
    end

    assign dout_data  = oreg;
    assign dout_valid = ovld;
  end else begin : g_combout
    assign dout_data  = head;
    assign dout_valid = rel;
  end

endmodule
